// File: rtl/wb_slave_regfile_if.sv
// Wishbone classic-cycle bus bundle for wb_slave_regfile.
// The signal names follow the slave's point of view (_i driven by the master, _o by the slave).
//   master modport : drives adr/dat_i/sel/we/cyc/stb/cti/bte, receives dat_o/ack/err/rty
//   slave modport  : the reverse
interface wb_slave_regfile_if #(
   parameter int dw = 32,
   parameter int aw = 32
);
   logic [aw-1:0] wb_adr_i;
   logic [dw-1:0] wb_dat_i;
   logic [3:0]    wb_sel_i;
   logic          wb_we_i;
   logic          wb_cyc_i;
   logic          wb_stb_i;
   logic [2:0]    wb_cti_i;
   logic [1:0]    wb_bte_i;
   logic [dw-1:0] wb_dat_o;
   logic          wb_ack_o;
   logic          wb_err_o;
   logic          wb_rty_o;

   modport master (
      output wb_adr_i, wb_dat_i, wb_sel_i, wb_we_i, wb_cyc_i, wb_stb_i, wb_cti_i, wb_bte_i,
      input  wb_dat_o, wb_ack_o, wb_err_o, wb_rty_o
   );

   modport slave (
      input  wb_adr_i, wb_dat_i, wb_sel_i, wb_we_i, wb_cyc_i, wb_stb_i, wb_cti_i, wb_bte_i,
      output wb_dat_o, wb_ack_o, wb_err_o, wb_rty_o
   );
endinterface

// File: rtl/wb_slave_regfile.sv
// Wishbone classic-cycle slave holding NUM_REGS 32-bit read/write registers at BASE_ADDR.
// Single transfers only; optional wait states; error termination on bad address or empty sel.
// Ports:
//   wb_clk, wb_rst : bus clock, asynchronous active-high reset
//   bus            : Wishbone slave modport (adr, dat, sel, we, cyc, stb, cti, bte / dat_o, ack, err, rty)
//   regs_o         : all registers flat, reg k at bits k*dw +: dw
//   wr_strobe_o    : one-cycle pulse on each successful register write
//   wr_index_o     : index of the most recently written register
module wb_slave_regfile #(
   parameter int            dw          = 32,
   parameter int            aw          = 32,
   parameter int            NUM_REGS    = 16,
   parameter logic [aw-1:0] BASE_ADDR   = '0,
   parameter int            WAIT_STATES = 0
) (
   input  logic                          wb_clk,
   input  logic                          wb_rst,
   wb_slave_regfile_if.slave             bus,
   output logic [NUM_REGS*dw-1:0]        regs_o,
   output logic                          wr_strobe_o,
   output logic [$clog2(NUM_REGS)-1:0]   wr_index_o
);

   localparam int            IW   = $clog2(NUM_REGS);
   localparam logic [aw-1:0] SPAN = aw'(NUM_REGS * 4);

   typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

   state_t        state, state_nx;
   logic [3:0]    cnt, cnt_nx;
   logic          req;
   logic          resp;

   // request captured in IDLE, used when the response is produced from WAIT
   logic [aw-1:0] adr_q;
   logic          we_q;
   logic [3:0]    sel_q;
   logic [dw-1:0] dat_q;

   // access currently being decoded: live bus in IDLE, latched copy otherwise
   logic [aw-1:0] acc_adr;
   logic          acc_we;
   logic [3:0]    acc_sel;
   logic [dw-1:0] acc_dat;
   logic [aw-1:0] off;
   logic          hit;
   logic [IW-1:0] idx;

   logic [dw-1:0] regs [NUM_REGS];
   logic [dw-1:0] dat;
   logic          ack;
   logic          err;

   logic          unused_bus;

   assign req = bus.wb_cyc_i & bus.wb_stb_i;

   // ---------------- state machine ----------------
   always_ff @(posedge wb_clk or posedge wb_rst) begin
      if (wb_rst) begin
         state <= IDLE;
         cnt   <= '0;
      end else begin
         state <= state_nx;
         cnt   <= cnt_nx;
      end
   end

   // resp marks the edge at which ack/err and any register write take effect
   always_comb begin
      state_nx = state;
      cnt_nx   = cnt;
      resp     = 1'b0;
      unique case (state)
         IDLE: begin
            if (req) begin
               if (WAIT_STATES == 0) begin
                  state_nx = RESP;
                  resp     = 1'b1;
               end else begin
                  state_nx = WAIT;
                  cnt_nx   = 4'(WAIT_STATES - 1);
               end
            end
         end
         WAIT: begin
            // a dropped cyc/stb abandons the access, even on the final wait cycle
            if (!req) begin
               state_nx = IDLE;
            end else if (cnt == '0) begin
               state_nx = RESP;
               resp     = 1'b1;
            end else begin
               cnt_nx = cnt - 4'd1;
            end
         end
         RESP:    state_nx = IDLE;
         default: state_nx = IDLE;
      endcase
   end

   // ---------------- request latch ----------------
   always_ff @(posedge wb_clk or posedge wb_rst) begin
      if (wb_rst) begin
         adr_q <= '0;
         we_q  <= 1'b0;
         sel_q <= '0;
         dat_q <= '0;
      end else if (state == IDLE && req) begin
         adr_q <= bus.wb_adr_i;
         we_q  <= bus.wb_we_i;
         sel_q <= bus.wb_sel_i;
         dat_q <= bus.wb_dat_i;
      end
   end

   // ---------------- address decode ----------------
   always_comb begin
      if (state == IDLE) begin
         acc_adr = bus.wb_adr_i;
         acc_we  = bus.wb_we_i;
         acc_sel = bus.wb_sel_i;
         acc_dat = bus.wb_dat_i;
      end else begin
         acc_adr = adr_q;
         acc_we  = we_q;
         acc_sel = sel_q;
         acc_dat = dat_q;
      end
      off = acc_adr - BASE_ADDR;
      hit = (acc_adr >= BASE_ADDR) && (off < SPAN) &&
            (acc_adr[1:0] == 2'b00) && (acc_sel != 4'b0000);
      idx = off[IW+1:2];
   end

   // ---------------- register file and response ----------------
   always_ff @(posedge wb_clk or posedge wb_rst) begin
      if (wb_rst) begin
         for (int unsigned k = 0; k < NUM_REGS; k++) regs[k] <= '0;
         dat         <= '0;
         ack         <= 1'b0;
         err         <= 1'b0;
         wr_strobe_o <= 1'b0;
         wr_index_o  <= '0;
      end else begin
         ack         <= 1'b0;
         err         <= 1'b0;
         wr_strobe_o <= 1'b0;
         if (resp) begin
            if (!hit) begin
               err <= 1'b1;
               dat <= '0;
            end else begin
               ack <= 1'b1;
               if (acc_we) begin
                  for (int unsigned b = 0; b < 4; b++) begin
                     if (acc_sel[b]) regs[idx][8*b +: 8] <= acc_dat[8*b +: 8];
                  end
                  dat         <= '0;
                  wr_strobe_o <= 1'b1;
                  wr_index_o  <= idx;
               end else begin
                  dat <= regs[idx];
               end
            end
         end
      end
   end

   always_comb begin
      for (int unsigned k = 0; k < NUM_REGS; k++) regs_o[k*dw +: dw] = regs[k];
   end

   assign bus.wb_dat_o = dat;
   assign bus.wb_ack_o = ack;
   assign bus.wb_err_o = err;
   assign bus.wb_rty_o = 1'b0;

   // cycle/burst type are accepted but every access is handled as classic
   assign unused_bus = ^{bus.wb_cti_i, bus.wb_bte_i};

endmodule
